pc_state_reg: RTL and testbench



---
 rtl/rv32i_types.sv | 12 +
 rtl/pc_state_reg_if.sv | 25 ++
 rtl/dff_en_ar.sv | 33 +++
 rtl/pc_state_reg.sv | 62 ++++++
 tb/tb_pc_state_reg.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/rv32i_types.sv
// Shared rv32i type and constant definitions used by the fetch-stage blocks.
package rv32i_types;

   typedef logic [31:0] rv32i_word;

   // First fetch address after reset.
   localparam rv32i_word PC_RESET_VECTOR = 32'h6000_0000;

   // Number of low PC bits that must be zero for a word-aligned fetch.
   localparam int PC_ALIGN_BITS = 2;

endpackage

// File: rtl/pc_state_reg_if.sv
// Next-PC load bus between the PC mux / fetch control (master) and the PC register (slave).
interface pc_state_reg_if #(
   parameter int WIDTH = 32
);

   logic             load;
   logic [WIDTH-1:0] in;
   logic [WIDTH-1:0] out;
   logic             misaligned;

   modport master (
      output load,
      output in,
      input  out,
      input  misaligned
   );

   modport slave (
      input  load,
      input  in,
      output out,
      output misaligned
   );

endinterface

// File: rtl/dff_en_ar.sv
// Enabled register with asynchronous active-high reset to a parameterised value.
module dff_en_ar #(
   parameter int               WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] data_d;
   logic [WIDTH-1:0] data_q;

   always_comb begin
      data_d = data_q;
      if (en) begin
         data_d = d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= RESET_VALUE;
      end else begin
         data_q <= data_d;
      end
   end

   assign q = data_q;

endmodule

// File: rtl/pc_state_reg.sv
// Fetch-stage program-counter register: captures the PC-mux result when load is high.
// Optional word-alignment check and forced alignment under `PC_ALIGN_CHECK_EN.
module pc_state_reg
   import rv32i_types::*;
#(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR)
) (
   input  logic          clk,
   input  logic          rst,
   pc_state_reg_if.slave pc
);

   logic [WIDTH-1:0] out_d;
   logic [WIDTH-1:0] out_q;

   always_comb begin
      out_d = pc.in;
`ifdef PC_ALIGN_CHECK_EN
      // Store only the word address; the dropped bits are reported via misaligned.
      out_d[PC_ALIGN_BITS-1:0] = '0;
`endif
   end

   dff_en_ar #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VECTOR)
   ) u_out_reg (
      .clk (clk),
      .rst (rst),
      .en  (pc.load),
      .d   (out_d),
      .q   (out_q)
   );

   assign pc.out = out_q;

`ifdef PC_ALIGN_CHECK_EN
   logic misaligned_d;
   logic misaligned_q;

   always_comb begin
      misaligned_d = |pc.in[PC_ALIGN_BITS-1:0];
   end

   dff_en_ar #(
      .WIDTH       (1),
      .RESET_VALUE (1'b0)
   ) u_misaligned_reg (
      .clk (clk),
      .rst (rst),
      .en  (pc.load),
      .d   (misaligned_d),
      .q   (misaligned_q)
   );

   assign pc.misaligned = misaligned_q;
`else
   assign pc.misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_pc_state_reg.sv
// Directed self-checking bench for pc_state_reg; honours `PC_ALIGN_CHECK_EN if defined.
module tb_pc_state_reg;

   logic clk;
   logic rst;

   pc_state_reg_if #(.WIDTH(32)) pc ();

   pc_state_reg dut (
      .clk (clk),
      .rst (rst),
      .pc  (pc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: what the PC must read as, from the register's stated rules.
   logic [31:0] m_out;
   logic        m_mis;
   bit          m_valid = 1'b0;

   function automatic logic [31:0] stored_pc(input logic [31:0] v);
`ifdef PC_ALIGN_CHECK_EN
      return (v / 4) * 4;
`else
      return v;
`endif
   endfunction

   function automatic logic flag_of(input logic [31:0] v);
`ifdef PC_ALIGN_CHECK_EN
      return (v % 4) != 0;
`else
      return 1'b0;
`endif
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_out   = 32'h6000_0000;
         m_mis   = 1'b0;
         m_valid = 1'b1;
      end else if (pc.load) begin
         m_out = stored_pc(pc.in);
         m_mis = flag_of(pc.in);
      end
   end

   // Cycle-by-cycle comparison away from the active edge.
   always @(negedge clk) begin
      if (m_valid) begin
         check("model_out", pc.out, m_out);
         check("model_misaligned", {31'b0, pc.misaligned}, {31'b0, m_mis});
      end
   end

   task automatic mid_cycle();
      @(negedge clk);
      #1;
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] vec [8];

   initial begin
      rst     = 1'b0;
      pc.load = 1'b0;
      pc.in   = '0;

      // Asynchronous reset with no clock edge involved.
      #2;
      rst = 1'b1;
      #1;
      check("async_reset_out", pc.out, 32'h6000_0000);
      check("async_reset_mis", {31'b0, pc.misaligned}, 32'h0);

      // Reset held across edges with load asserted keeps the reset vector.
      pc.load = 1'b1;
      pc.in   = 32'h1234_5678;
      after_edge();
      after_edge();
      check("reset_priority", pc.out, 32'h6000_0000);

      mid_cycle();
      rst   = 1'b0;
      pc.in = 32'h6000_0004;
      after_edge();
      check("first_load", pc.out, 32'h6000_0004);

      // Hold with load low.
      mid_cycle();
      pc.load = 1'b0;
      pc.in   = 32'hDEAD_BEE0;
      after_edge();
      after_edge();
      after_edge();
      check("hold_3_edges", pc.out, 32'h6000_0004);

      // Input change between edges: only the value at the edge counts.
      mid_cycle();
      pc.load = 1'b1;
      pc.in   = 32'h6000_0010;
      #2;
      pc.in   = 32'h6000_0020;
      #1;
      check("no_comb_path", pc.out, 32'h6000_0004);
      after_edge();
      check("mid_change_load", pc.out, 32'h6000_0020);

      // Mid-cycle reset pulse while loading.
      mid_cycle();
      pc.in = 32'h6000_0030;
      rst   = 1'b1;
      #1;
      check("pulse_reset_out", pc.out, 32'h6000_0000);
      #1;
      rst = 1'b0;
      #1;
      check("pulse_reset_held", pc.out, 32'h6000_0000);
      after_edge();
      check("load_after_release", pc.out, 32'h6000_0030);

      // Misaligned load.
      mid_cycle();
      pc.in = 32'h6000_0006;
      after_edge();
`ifdef PC_ALIGN_CHECK_EN
      check("misalign_out", pc.out, 32'h6000_0004);
      check("misalign_flag", {31'b0, pc.misaligned}, 32'h1);
`else
      check("misalign_out", pc.out, 32'h6000_0006);
      check("misalign_flag", {31'b0, pc.misaligned}, 32'h0);
`endif

      // Flag and PC hold when load is low.
      mid_cycle();
      pc.load = 1'b0;
      pc.in   = 32'h0000_0000;
      after_edge();
`ifdef PC_ALIGN_CHECK_EN
      check("misalign_hold", {31'b0, pc.misaligned}, 32'h1);
`else
      check("misalign_hold", {31'b0, pc.misaligned}, 32'h0);
`endif

      // Back-to-back loads with mixed low bits.
      vec[0] = 32'h6000_0100; vec[1] = 32'h6000_0101;
      vec[2] = 32'h6000_0102; vec[3] = 32'h6000_0103;
      vec[4] = 32'hFFFF_FFFC; vec[5] = 32'hFFFF_FFFF;
      vec[6] = 32'h0000_0000; vec[7] = 32'h8000_0008;
      mid_cycle();
      pc.load = 1'b1;
      for (int i = 0; i < 8; i++) begin
         pc.in = vec[i];
         after_edge();
         check("b2b_out", pc.out, stored_pc(vec[i]));
         mid_cycle();
      end
      pc.load = 1'b0;

      // Final reset clears the flag.
      rst = 1'b1;
      #1;
      check("final_reset_out", pc.out, 32'h6000_0000);
      check("final_reset_mis", {31'b0, pc.misaligned}, 32'h0);
      after_edge();
      mid_cycle();
      rst = 1'b0;
      after_edge();
      mid_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
